traffic_scheduler: RTL

TRAFFIC_SCHEDULER -- requirements
Module: traffic_scheduler

---
 rtl/traffic_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/traffic_scheduler.sv
// ---------------------------------------------------------------------------
// traffic_scheduler
//   Four-way intersection controller with one green direction at a time,
//   round-robin service of latched vehicle requests and emergency preemption.
//   Every phase change goes GREEN -> YELLOW -> ALL_RED -> GREEN.
//   Phase timers count `tick` pulses, not clock cycles.
//
// Parameters
//   MIN_GREEN  minimum green duration in ticks, before a contested green may end
//   MAX_GREEN  green duration after which a contested green ends even if the
//              green direction still has a vehicle waiting
//   YELLOW     yellow duration in ticks
//   ALL_RED    all-red clearance duration in ticks
//
// Ports
//   clk                 rising-edge clock
//   rst_a_n             asynchronous active-low reset
//   tick                one-cycle timebase enable
//   veh_req[3:0]        vehicle sensors, one bit per direction (0=N 1=S 2=E 3=W)
//   emg, emg_dir[1:0]   emergency preemption request and its direction
//   n/s/e/w_lights[2:0] lamp drive: 001 green, 010 yellow, 100 red
//   phase[1:0]          00 ALL_RED, 01 GREEN, 10 YELLOW
//   cur_dir[1:0]        direction currently or most recently green
//   pend[3:0]           latched pending-request vector
// ---------------------------------------------------------------------------
module traffic_scheduler #(
  parameter int unsigned MIN_GREEN = 4,
  parameter int unsigned MAX_GREEN = 8,
  parameter int unsigned YELLOW    = 3,
  parameter int unsigned ALL_RED   = 2
) (
  input  logic       clk,
  input  logic       rst_a_n,
  input  logic       tick,
  input  logic [3:0] veh_req,
  input  logic       emg,
  input  logic [1:0] emg_dir,
  output logic [2:0] n_lights,
  output logic [2:0] s_lights,
  output logic [2:0] e_lights,
  output logic [2:0] w_lights,
  output logic [1:0] phase,
  output logic [1:0] cur_dir,
  output logic [3:0] pend
);

  // The encoding doubles as the phase output value.
  typedef enum logic [1:0] {
    ST_ALL_RED = 2'b00,
    ST_GREEN   = 2'b01,
    ST_YELLOW  = 2'b10
  } state_e;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;

  state_e          state_q, state_d;
  logic [1:0]      dir_q, dir_d;
  logic [3:0]      elapsed_q, elapsed_d;
  logic [3:0]      pend_q, pend_d;
  logic [3:0][2:0] lamp_q, lamp_d;

  logic [3:0] elapsed_tick;   // timer value after this cycle's tick, saturated
  logic       others_pend;    // some direction other than the green one waits
  logic       rr_found;
  logic [1:0] rr_dir;
  logic       grant;          // a direction enters GREEN on this edge

  assign elapsed_tick = (tick && (elapsed_q != 4'hF)) ? elapsed_q + 4'd1 : elapsed_q;
  assign others_pend  = |(pend_q & ~(4'b0001 << dir_q));

  // Round-robin search starting after the last green direction; k=4 wraps
  // back onto dir_q so the previous holder is considered last.
  // NOTE: every variable assigned in a combinational block gets a default at
  // the top, so no path can leave it unassigned and infer a latch.
  always_comb begin
    rr_found = 1'b0;
    rr_dir   = dir_q;
    for (int k = 1; k <= 4; k++) begin
      if (!rr_found && pend_q[dir_q + k[1:0]]) begin
        rr_found = 1'b1;
        rr_dir   = dir_q + k[1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    grant   = 1'b0;

    unique case (state_q)
      ST_ALL_RED: begin
        // Once clearance has elapsed the search is retried on every tick.
        if (tick && (elapsed_tick >= 4'(ALL_RED))) begin
          if (emg) begin
            state_d = ST_GREEN;
            dir_d   = emg_dir;
            grant   = 1'b1;
          end else if (rr_found) begin
            state_d = ST_GREEN;
            dir_d   = rr_dir;
            grant   = 1'b1;
          end
        end
      end
      ST_GREEN: begin
        if (emg) begin
          // Preemption ends a conflicting green at once; a matching one is held.
          if (emg_dir != dir_q) state_d = ST_YELLOW;
        end else if (tick && (elapsed_tick >= 4'(MIN_GREEN)) && others_pend &&
                     (!veh_req[dir_q] || (elapsed_tick >= 4'(MAX_GREEN)))) begin
          state_d = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (tick && (elapsed_tick >= 4'(YELLOW))) state_d = ST_ALL_RED;
      end
      default: state_d = ST_ALL_RED;
    endcase

    elapsed_d = (state_d != state_q) ? 4'd0 : elapsed_tick;

    // Entering GREEN clears that direction's request, overriding a new one.
    pend_d = pend_q | veh_req;
    if (grant) pend_d[dir_d] = 1'b0;

    // Lamps are decoded from the next state so they switch on the same edge.
    for (int i = 0; i < 4; i++) begin
      lamp_d[i] = LAMP_RED;
      if (dir_d == 2'(i)) begin
        if (state_d == ST_GREEN)  lamp_d[i] = LAMP_GREEN;
        if (state_d == ST_YELLOW) lamp_d[i] = LAMP_YELLOW;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_q   <= ST_ALL_RED;
      dir_q     <= 2'd3;          // first search after reset starts at N
      elapsed_q <= 4'd0;
      pend_q    <= 4'd0;
      lamp_q    <= {4{LAMP_RED}};
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      elapsed_q <= elapsed_d;
      pend_q    <= pend_d;
      lamp_q    <= lamp_d;
    end
  end

  assign n_lights = lamp_q[0];
  assign s_lights = lamp_q[1];
  assign e_lights = lamp_q[2];
  assign w_lights = lamp_q[3];
  assign phase    = state_q;
  assign cur_dir  = dir_q;
  assign pend     = pend_q;

endmodule
